uart_echo_buffer: RTL and testbench

//  Parametrised loopback engine between a UART RX and TX core (Uart_Interface handshake).

---
 rtl/uart_echo_pkg.sv | 11 +
 rtl/uart_echo_ram.sv | 22 ++
 rtl/uart_echo_buffer.sv | 115 +++++++++++
 tb/tb_uart_echo_buffer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: shared FSM encoding, stats width and clog2 helper for the UART echo buffer
package uart_echo_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT} echo_state_t;
  localparam int STAT_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_echo_ram.sv
// uart_echo_ram: simple dual-port RAM, synchronous write, registered read, no array reset
module uart_echo_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              Clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_echo_buffer.sv
// uart_echo_buffer: RX->FIFO->TX loopback with flush, pause, overflow and TX watchdog; UART_ECHO_STATS_EN adds error/drop counters
module uart_echo_buffer
  import uart_echo_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int TX_TIMEOUT = 4096
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        iEcho_En,
  input  logic                        iFlush,
  input  logic                        iRx_Val,
  input  logic                        iRx_err,
  input  logic [DATA_W-1:0]           iRx_Data,
  input  logic                        iTx_Rdy,
  input  logic                        iTx_done,
  output logic                        oTx_Val,
  output logic [DATA_W-1:0]           oTx_Data,
  output logic [clog2(FIFO_DEPTH):0]  oLevel,
  output logic                        oEmpty,
  output logic                        oFull,
  output logic                        oOvf,
  output logic                        oTx_Tmo
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [STAT_W-1:0]           oErr_Cnt,
  output logic [STAT_W-1:0]           oDrop_Cnt
`endif
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = clog2(TX_TIMEOUT);
  echo_state_t       r_state, w_next;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [TW-1:0]     r_timer;
  logic [DATA_W-1:0] r_tx_data, w_rdata;
  logic              r_tx_val, r_ovf, r_tmo;
  logic              w_wr, w_rd, w_ovf, w_tmo, w_accept;
  assign oEmpty   = r_level == '0;
  assign oFull    = r_level == LW'(FIFO_DEPTH);
  assign oLevel   = r_level;
  assign oTx_Val  = r_tx_val;
  assign oTx_Data = r_tx_data;
  assign oOvf     = r_ovf;
  assign oTx_Tmo  = r_tmo;
  assign w_wr     = iRx_Val & ~iRx_err & ~oFull & ~iFlush;
  assign w_ovf    = iRx_Val & ~iRx_err & oFull & ~iFlush;
  assign w_rd     = r_state == FETCH;
  assign w_accept = (r_state == SEND) & r_tx_val & iTx_Rdy;
  assign w_tmo    = (r_state == WAIT) & ~iTx_done & (r_timer == TW'(TX_TIMEOUT - 1));
  uart_echo_ram #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .AW(AW)) u_ram (
    .Clk    (Clk),
    .i_we   (w_wr),
    .i_waddr(r_wr_ptr),
    .i_wdata(iRx_Data),
    .i_re   (w_rd),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rdata)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (~oEmpty & iEcho_En & ~iFlush) ? FETCH : IDLE;
      FETCH:   w_next = SEND;
      SEND:    w_next = w_accept ? WAIT : SEND;
      WAIT:    w_next = (iTx_done | w_tmo) ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // oTx_Val/oTx_Data are registered: the first SEND cycle latches the RAM word, so the offer is glitch-free and stable
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_timer   <= '0;
      r_tx_val  <= 1'b0;
      r_tx_data <= '0;
      r_ovf     <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_wr_ptr <= iFlush ? '0 : r_wr_ptr + AW'(w_wr);
      r_rd_ptr <= iFlush ? '0 : r_rd_ptr + AW'(w_rd);
      r_level  <= iFlush ? '0 : r_level + LW'(w_wr) - LW'(w_rd);
      r_timer  <= (r_state == WAIT) ? r_timer + TW'(1) : '0;
      r_tx_val <= (r_state == SEND) & ~w_accept;
      if ((r_state == SEND) & ~r_tx_val) r_tx_data <= w_rdata;
      r_ovf    <= w_ovf;
      r_tmo    <= w_tmo;
    end
  end
`ifdef UART_ECHO_STATS_EN
  logic [STAT_W-1:0] r_err_cnt, r_drop_cnt;
  logic [1:0]        w_drop_inc;
  assign w_drop_inc = {1'b0, w_ovf} + {1'b0, w_tmo};
  assign oErr_Cnt   = r_err_cnt;
  assign oDrop_Cnt  = r_drop_cnt;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else if (iFlush) begin
      r_err_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_err_cnt  <= (iRx_Val & iRx_err & ~&r_err_cnt) ? r_err_cnt + STAT_W'(1) : r_err_cnt;
      r_drop_cnt <= (r_drop_cnt > ('1 - STAT_W'(w_drop_inc))) ? '1 : r_drop_cnt + STAT_W'(w_drop_inc);
    end
  end
`endif
endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb_uart_echo_buffer: directed scenario tests for uart_echo_buffer with TX_TIMEOUT=8
module tb_uart_echo_buffer;
  logic       Clk = 1'b0, Rst = 1'b1;
  logic       iEcho_En = 1'b0, iFlush = 1'b0, iRx_Val = 1'b0, iRx_err = 1'b0;
  logic [7:0] iRx_Data = '0;
  logic       iTx_Rdy = 1'b0, iTx_done = 1'b0;
  logic       oTx_Val, oEmpty, oFull, oOvf, oTx_Tmo;
  logic [7:0] oTx_Data;
  logic [4:0] oLevel;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] oErr_Cnt, oDrop_Cnt;
`endif
  int n_tests = 0, n_fail = 0;
  uart_echo_buffer #(.DATA_W(8), .FIFO_DEPTH(16), .TX_TIMEOUT(8)) dut (
    .Clk(Clk), .Rst(Rst), .iEcho_En(iEcho_En), .iFlush(iFlush), .iRx_Val(iRx_Val),
    .iRx_err(iRx_err), .iRx_Data(iRx_Data), .iTx_Rdy(iTx_Rdy), .iTx_done(iTx_done),
    .oTx_Val(oTx_Val), .oTx_Data(oTx_Data), .oLevel(oLevel), .oEmpty(oEmpty),
    .oFull(oFull), .oOvf(oOvf), .oTx_Tmo(oTx_Tmo)
`ifdef UART_ECHO_STATS_EN
    , .oErr_Cnt(oErr_Cnt), .oDrop_Cnt(oDrop_Cnt)
`endif
  );
  always #5 Clk = ~Clk;
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic wait_val();
    int k;
    k = 0;
    while (oTx_Val !== 1'b1 && k < 20) begin
      step();
      k++;
    end
  endtask
  task automatic done_pulse();
    iTx_done = 1'b1;
    step();
    iTx_done = 1'b0;
  endtask
  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({oTx_Val, oTx_Data, oLevel, oEmpty, oFull, oOvf, oTx_Tmo} !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: val=%b data=%h lvl=%0d e=%b f=%b ovf=%b tmo=%b, need 0 00 0 1 0 0 0", oTx_Val, oTx_Data, oLevel, oEmpty, oFull, oOvf, oTx_Tmo);
    end
`ifdef UART_ECHO_STATS_EN
    n_tests++;
    if ({oErr_Cnt, oDrop_Cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_stats: err=%0d drop=%0d, need 0 0", oErr_Cnt, oDrop_Cnt); end
`endif
    Rst = 1'b0;
    step();
  endtask
  task automatic test_single_echo();
    iEcho_En = 1'b1; iTx_Rdy = 1'b1;
    iRx_Val = 1'b1; iRx_Data = 8'hA5;
    step();
    iRx_Val = 1'b0;
    n_tests++;
    if (oLevel !== 5'd1 || oTx_Val !== 1'b0) begin n_fail++; $display("FAIL single_E0: lvl=%0d val=%b, need 1 0", oLevel, oTx_Val); end
    step();
    step();
    n_tests++;
    if (oLevel !== 5'd0 || oTx_Val !== 1'b0) begin n_fail++; $display("FAIL single_E2: lvl=%0d val=%b, need 0 0", oLevel, oTx_Val); end
    step();
    n_tests++;
    if (oTx_Val !== 1'b1 || oTx_Data !== 8'hA5) begin n_fail++; $display("FAIL single_E3: val=%b data=%h, need 1 a5", oTx_Val, oTx_Data); end
    step();
    n_tests++;
    if (oTx_Val !== 1'b0) begin n_fail++; $display("FAIL single_accept: val=%b, need 0", oTx_Val); end
    done_pulse();
    step();
    n_tests++;
    if (oEmpty !== 1'b1 || oTx_Val !== 1'b0) begin n_fail++; $display("FAIL single_done: empty=%b val=%b, need 1 0", oEmpty, oTx_Val); end
  endtask
  task automatic test_burst_overflow();
    iEcho_En = 1'b0;
    for (int i = 0; i < 16; i++) begin
      iRx_Val = 1'b1; iRx_Data = 8'(i);
      step();
    end
    iRx_Val = 1'b0;
    n_tests++;
    if (oFull !== 1'b1 || oLevel !== 5'd16 || oOvf !== 1'b0) begin n_fail++; $display("FAIL burst_full: full=%b lvl=%0d ovf=%b, need 1 16 0", oFull, oLevel, oOvf); end
    iRx_Val = 1'b1; iRx_Data = 8'hEE;
    step();
    iRx_Val = 1'b0;
    n_tests++;
    if (oOvf !== 1'b1 || oLevel !== 5'd16) begin n_fail++; $display("FAIL burst_ovf: ovf=%b lvl=%0d, need 1 16", oOvf, oLevel); end
    step();
    n_tests++;
    if (oOvf !== 1'b0) begin n_fail++; $display("FAIL burst_ovf_pulse: ovf=%b, need 0", oOvf); end
    iEcho_En = 1'b1; iTx_Rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_val();
      n_tests++;
      if (oTx_Val !== 1'b1 || oTx_Data !== 8'(i)) begin n_fail++; $display("FAIL burst_order[%0d]: val=%b data=%h, need 1 %h", i, oTx_Val, oTx_Data, 8'(i)); end
      step();
      n_tests++;
      if (oTx_Val !== 1'b0) begin n_fail++; $display("FAIL burst_b2b[%0d]: val=%b, need 0", i, oTx_Val); end
      done_pulse();
    end
    repeat (6) begin
      step();
      n_tests++;
      if (oTx_Val !== 1'b0 || oEmpty !== 1'b1) begin n_fail++; $display("FAIL burst_drained: val=%b empty=%b, need 0 1", oTx_Val, oEmpty); end
    end
  endtask
  task automatic test_errored();
    iRx_Val = 1'b1; iRx_err = 1'b1; iRx_Data = 8'h55;
    step();
    iRx_Val = 1'b0; iRx_err = 1'b0;
    repeat (6) begin
      step();
      n_tests++;
      if (oLevel !== 5'd0 || oTx_Val !== 1'b0) begin n_fail++; $display("FAIL err_not_stored: lvl=%0d val=%b, need 0 0", oLevel, oTx_Val); end
    end
`ifdef UART_ECHO_STATS_EN
    n_tests++;
    if (oErr_Cnt !== 16'd1 || oDrop_Cnt !== 16'd1) begin n_fail++; $display("FAIL err_stats: err=%0d drop=%0d, need 1 1", oErr_Cnt, oDrop_Cnt); end
`endif
  endtask
  task automatic test_watchdog();
    iEcho_En = 1'b1; iTx_Rdy = 1'b1;
    iRx_Val = 1'b1; iRx_Data = 8'h31;
    step();
    iRx_Data = 8'h32;
    step();
    iRx_Val = 1'b0;
    wait_val();
    n_tests++;
    if (oTx_Val !== 1'b1 || oTx_Data !== 8'h31) begin n_fail++; $display("FAIL wdog_first: val=%b data=%h, need 1 31", oTx_Val, oTx_Data); end
    step();
    for (int k = 1; k < 8; k++) begin
      step();
      n_tests++;
      if (oTx_Tmo !== 1'b0) begin n_fail++; $display("FAIL wdog_early[%0d]: tmo=%b, need 0", k, oTx_Tmo); end
    end
    step();
    n_tests++;
    if (oTx_Tmo !== 1'b1) begin n_fail++; $display("FAIL wdog_pulse: tmo=%b, need 1", oTx_Tmo); end
    step();
    n_tests++;
    if (oTx_Tmo !== 1'b0) begin n_fail++; $display("FAIL wdog_pulse_end: tmo=%b, need 0", oTx_Tmo); end
    wait_val();
    n_tests++;
    if (oTx_Val !== 1'b1 || oTx_Data !== 8'h32) begin n_fail++; $display("FAIL wdog_next: val=%b data=%h, need 1 32", oTx_Val, oTx_Data); end
    step();
    done_pulse();
`ifdef UART_ECHO_STATS_EN
    n_tests++;
    if (oDrop_Cnt !== 16'd2) begin n_fail++; $display("FAIL wdog_stats: drop=%0d, need 2", oDrop_Cnt); end
`endif
  endtask
  task automatic test_flush();
    iEcho_En = 1'b0; iTx_Rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iRx_Val = 1'b1; iRx_Data = 8'h41 + 8'(i);
      step();
    end
    iRx_Val = 1'b0;
    iEcho_En = 1'b1;
    wait_val();
    n_tests++;
    if (oTx_Val !== 1'b1 || oTx_Data !== 8'h41 || oLevel !== 5'd3) begin n_fail++; $display("FAIL flush_send: val=%b data=%h lvl=%0d, need 1 41 3", oTx_Val, oTx_Data, oLevel); end
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    n_tests++;
    if (oLevel !== 5'd0 || oEmpty !== 1'b1 || oTx_Val !== 1'b1 || oTx_Data !== 8'h41) begin n_fail++; $display("FAIL flush_clear: lvl=%0d empty=%b val=%b data=%h, need 0 1 1 41", oLevel, oEmpty, oTx_Val, oTx_Data); end
`ifdef UART_ECHO_STATS_EN
    n_tests++;
    if ({oErr_Cnt, oDrop_Cnt} !== 32'h0) begin n_fail++; $display("FAIL flush_stats: err=%0d drop=%0d, need 0 0", oErr_Cnt, oDrop_Cnt); end
`endif
    iTx_Rdy = 1'b1;
    step();
    n_tests++;
    if (oTx_Val !== 1'b0) begin n_fail++; $display("FAIL flush_accept: val=%b, need 0", oTx_Val); end
    done_pulse();
    repeat (8) begin
      step();
      n_tests++;
      if (oTx_Val !== 1'b0) begin n_fail++; $display("FAIL flush_no_tx: val=%b, need 0", oTx_Val); end
    end
  endtask
  task automatic test_rst_mid_frame();
    iEcho_En = 1'b1; iTx_Rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iRx_Val = 1'b1; iRx_Data = 8'h60 + 8'(i);
      step();
    end
    iRx_Val = 1'b0;
    n_tests++;
    if (oLevel !== 5'd5 || oTx_Val !== 1'b0) begin n_fail++; $display("FAIL rst_pre_wait: lvl=%0d val=%b, need 5 0", oLevel, oTx_Val); end
    #2 Rst = 1'b1;
    #1;
    n_tests++;
    if ({oTx_Val, oTx_Data, oLevel, oEmpty, oFull, oOvf, oTx_Tmo} !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: val=%b data=%h lvl=%0d e=%b f=%b ovf=%b tmo=%b, need 0 00 0 1 0 0 0", oTx_Val, oTx_Data, oLevel, oEmpty, oFull, oOvf, oTx_Tmo);
    end
    step();
    Rst = 1'b0;
    repeat (6) begin
      step();
      n_tests++;
      if (oTx_Val !== 1'b0 || oEmpty !== 1'b1) begin n_fail++; $display("FAIL rst_lost: val=%b empty=%b, need 0 1", oTx_Val, oEmpty); end
    end
  endtask
  initial begin
    test_reset();
    test_single_echo();
    test_burst_overflow();
    test_errored();
    test_watchdog();
    test_flush();
    test_rst_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
